// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state type and frame constants for the UART receiver.
//   uart_rx_state_t : receiver FSM states
//   OVERSAMPLE      : ticks per serial bit
//   DATA_BITS       : payload bits per frame
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks, restartable for phase alignment.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clear : restart the divider at 0
//   tick  : one-cycle pulse every DIV cycles
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clear || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, glitch reject and break handling.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   rx         : asynchronous serial input, idle high
//   uart_data  : last good byte, updated only with uart_valid
//   uart_valid : one-cycle strobe for a new uart_data
//   frame_err  : one-cycle strobe for a low stop bit
//   busy       : receiver not in IDLE
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = 18_432_000,
    parameter int BAUD     = 115_200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] uart_data,
    output logic                 uart_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV  = CLK_FREQ / (OVERSAMPLE * BAUD);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BI_W = $clog2(DATA_BITS);

    logic [1:0]           r_sync;
    uart_rx_state_t       r_state, w_state_nxt;
    logic [OS_W-1:0]      r_os_cnt, w_os_nxt;
    logic [BI_W-1:0]      r_bit_idx, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt, r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt, r_ferr, w_ferr_nxt;
    logic                 w_rx_s, w_tick, w_clear, w_last_os;

    assign w_rx_s     = r_sync[1];
    assign w_last_os  = w_tick && (r_os_cnt == OS_W'(OVERSAMPLE - 1));
    assign uart_data  = r_data;
    assign uart_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_state   <= w_state_nxt;
            r_os_cnt  <= w_os_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    // The oversample count wraps 15->0 on its own, so every bit slot after
    // mid-start is exactly 16 ticks without an explicit reload.
    always_comb begin
        w_state_nxt = r_state;
        w_os_nxt    = r_os_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_clear     = 1'b1;
                    w_os_nxt    = '0;
                    w_bit_nxt   = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_os_nxt = r_os_cnt + 1'b1;
                    if (r_os_cnt == OS_W'(OVERSAMPLE / 2 - 1)) begin
                        w_state_nxt = w_rx_s ? IDLE : DATA;
                        w_os_nxt    = '0;
                    end
                end
            end
            DATA: begin
                if (w_tick)
                    w_os_nxt = r_os_cnt + 1'b1;
                if (w_last_os) begin
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit_idx + 1'b1;
                    if (r_bit_idx == BI_W'(DATA_BITS - 1))
                        w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tick)
                    w_os_nxt = r_os_cnt + 1'b1;
                if (w_last_os) begin
                    w_state_nxt = w_rx_s ? IDLE : BREAK;
                    w_data_nxt  = w_rx_s ? r_shift : r_data;
                    w_valid_nxt = w_rx_s;
                    w_ferr_nxt  = !w_rx_s;
                end
            end
            BREAK: begin
                if (w_rx_s)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at default parameters (160 clk per bit).
module tb_uart_rx;

    localparam int BT = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] uart_data;
    logic       uart_valid, frame_err, busy;

    int         n_chk = 0, n_fail = 0, n_valid = 0, n_ferr = 0, v0, f0;
    logic [7:0] sb_q[$];
    logic [7:0] last_data = 8'h00;
    logic       prev_strobe = 1'b0;

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int bt, input logic stop);
        rx = 1'b0;
        wait_clk(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(bt);
        end
        rx = stop;
        wait_clk(bt);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (uart_valid || frame_err) begin
                chk("strobe_excl", 32'(uart_valid & frame_err), 32'd0);
                chk("strobe_2cyc", 32'(prev_strobe), 32'd0);
            end
            if (uart_valid) begin
                n_valid++;
                chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0)
                    chk("sb_data", 32'(uart_data), 32'(sb_q.pop_front()));
            end else if (uart_data !== last_data) begin
                chk("data_stable", 32'(uart_data), 32'(last_data));
            end
            if (frame_err)
                n_ferr++;
        end
        prev_strobe = uart_valid | frame_err;
        last_data   = uart_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        wait_clk(3);
        chk("rst_data", 32'(uart_data), 32'h00);
        chk("rst_valid", 32'(uart_valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clk(20);
        chk("idle_busy", 32'(busy), 32'd0);

        v0 = n_valid; f0 = n_ferr;
        sb_q.push_back(8'hA5);
        send(8'hA5, BT, 1'b1);
        wait_clk(BT);
        chk("a5_count", 32'(n_valid - v0), 32'd1);
        chk("a5_data", 32'(uart_data), 32'hA5);
        chk("a5_ferr", 32'(n_ferr - f0), 32'd0);

        v0 = n_valid;
        sb_q.push_back(8'h01);
        sb_q.push_back(8'h2F);
        send(8'h01, BT, 1'b1);
        send(8'h2F, BT, 1'b1);
        wait_clk(BT);
        chk("b2b_count", 32'(n_valid - v0), 32'd2);
        chk("b2b_data", 32'(uart_data), 32'h2F);

        v0 = n_valid; f0 = n_ferr;
        send(8'h3C, BT, 1'b0);
        wait_clk(BT);
        chk("ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("ferr_novalid", 32'(n_valid - v0), 32'd0);
        chk("ferr_data", 32'(uart_data), 32'h2F);
        chk("brk_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_clk(1);
        chk("brk_busy_hold", 32'(busy), 32'd1);
        wait_clk(4);
        chk("brk_exit", 32'(busy), 32'd0);
        wait_clk(BT);

        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        wait_clk(10);
        chk("glitch_start", 32'(busy), 32'd1);
        wait_clk(30);
        rx = 1'b1;
        wait_clk(44);
        chk("glitch_idle", 32'(busy), 32'd0);
        wait_clk(BT);
        chk("glitch_nostrobe", 32'(n_valid - v0 + n_ferr - f0), 32'd0);

        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        wait_clk(BT);
        rx = 1'b1;
        wait_clk(4 * BT + BT / 2);
        rst_n = 1'b0;
        wait_clk(2);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", 32'(uart_data), 32'h00);
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5 * BT);
        chk("abort_nostrobe", 32'(n_valid - v0 + n_ferr - f0), 32'd0);
        sb_q.push_back(8'h12);
        send(8'h12, BT, 1'b1);
        wait_clk(BT);
        chk("abort_count", 32'(n_valid - v0), 32'd1);
        chk("abort_next", 32'(uart_data), 32'h12);

        v0 = n_valid; f0 = n_ferr;
        sb_q.push_back(8'h55);
        send(8'h55, 157, 1'b1);
        wait_clk(BT);
        chk("fast_count", 32'(n_valid - v0), 32'd1);
        sb_q.push_back(8'h55);
        send(8'h55, 163, 1'b1);
        wait_clk(BT);
        chk("slow_count", 32'(n_valid - v0), 32'd2);
        chk("skew_data", 32'(uart_data), 32'h55);
        chk("skew_ferr", 32'(n_ferr - f0), 32'd0);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
